// File: rtl/timer_ctrl.sv
// timer_ctrl: bus-facing control stage in front of the timer counter core.
// Holds the prescaler/timer configuration, turns CTRL writes into one-cycle
// start/stop pulses for the core and tracks the core's ready handshake with
// a three-state FSM (IDLE -> ARM -> RUN).
// Optional feature macro: TIMER_CTRL_PERIODIC_EN (periodic auto-restart and
// a readable/clearable expiry counter). Without it the block is one-shot only.
module timer_ctrl #(
  parameter logic [7:0] ADDR_CTRL       = 8'h08,
  parameter logic [7:0] ADDR_STATUS     = 8'h09,
  parameter logic [7:0] ADDR_PRESCALER  = 8'h0a,
  parameter logic [7:0] ADDR_TIMER      = 8'h0b,
  parameter logic [7:0] ADDR_EXPIRY_CNT = 8'h0c
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [31:0] core_prescaler_value,
  output logic [31:0] core_timer_value,
  output logic        core_start,
  output logic        core_stop,
  input  logic [31:0] core_curr_timer,
  input  logic        core_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] prescaler_q, prescaler_d;
  logic [31:0] timer_q, timer_d;
  logic        expired_q, expired_d;
  logic [31:0] expiry_cnt_q, expiry_cnt_d;
  logic        core_start_q, core_start_d;
  logic        core_stop_q, core_stop_d;
  logic        stop_req_q, stop_req_d;

  logic        wr_s;
  logic        wr_ctrl_s;
  logic        wr_status_s;
  logic        wr_presc_s;
  logic        wr_timer_s;
  logic        start_wr_s;
  logic        stop_wr_s;
  logic        idle_s;
  logic        expiry_s;
  logic        periodic_s;

  // Bus write decode; the bus never stalls so ready simply follows cs.
  assign wr_s        = cs & we;
  assign wr_ctrl_s   = wr_s && (address == ADDR_CTRL);
  assign wr_status_s = wr_s && (address == ADDR_STATUS);
  assign wr_presc_s  = wr_s && (address == ADDR_PRESCALER);
  assign wr_timer_s  = wr_s && (address == ADDR_TIMER);
  assign start_wr_s  = wr_ctrl_s & write_data[0];
  assign stop_wr_s   = wr_ctrl_s & write_data[1];
  assign idle_s      = (state_q == ST_IDLE);
  assign ready       = cs;

`ifdef TIMER_CTRL_PERIODIC_EN
  logic periodic_q, periodic_d;
  logic wr_expcnt_s;

  assign wr_expcnt_s = wr_s && (address == ADDR_EXPIRY_CNT);
  assign periodic_s  = periodic_q;

  // Periodic mode bit: writable at any time, sampled at the next expiry.
  always_comb begin
    periodic_d = periodic_q;
    if (wr_ctrl_s) begin
      periodic_d = write_data[2];
    end else begin
      periodic_d = periodic_q;
    end
  end

  // Periodic mode register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      periodic_q <= 1'b0;
    end else begin
      periodic_q <= periodic_d;
    end
  end
`else
  assign periodic_s = 1'b0;
`endif

  // Handshake FSM: start/stop pulse generation, stop latching and expiry detect.
  always_comb begin
    state_d      = state_q;
    stop_req_d   = stop_req_q;
    core_start_d = 1'b0;
    core_stop_d  = 1'b0;
    expiry_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stop_req_d = 1'b0;
        if (start_wr_s) begin
          state_d      = ST_ARM;
          core_start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (stop_wr_s) begin
          stop_req_d = 1'b1;
        end else begin
          stop_req_d = stop_req_q;
        end
        // The core has taken the start once it drops ready; any stop that
        // arrived while arming is forwarded on entry to RUN.
        if (!core_ready) begin
          state_d     = ST_RUN;
          core_stop_d = stop_req_q | stop_wr_s;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_RUN: begin
        if (core_ready) begin
          expiry_s = ~stop_req_q;
          if (periodic_s && !stop_req_q && !stop_wr_s) begin
            state_d      = ST_ARM;
            core_start_d = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            stop_req_d = 1'b0;
          end
        end else if (stop_wr_s && !stop_req_q) begin
          stop_req_d  = 1'b1;
          core_stop_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        stop_req_d = 1'b0;
      end
    endcase
  end

  // Configuration and status next-state: config only changes while idle,
  // a natural expiry beats a same-cycle clear of the sticky expired bit.
  always_comb begin
    prescaler_d  = prescaler_q;
    timer_d      = timer_q;
    expired_d    = expired_q;
    expiry_cnt_d = expiry_cnt_q;
    if (wr_presc_s && idle_s) begin
      prescaler_d = write_data;
    end else begin
      prescaler_d = prescaler_q;
    end
    if (wr_timer_s && idle_s) begin
      timer_d = write_data;
    end else begin
      timer_d = timer_q;
    end
    if (expiry_s) begin
      expired_d = 1'b1;
    end else if (wr_status_s && write_data[1]) begin
      expired_d = 1'b0;
    end else begin
      expired_d = expired_q;
    end
    if (expiry_s) begin
      expiry_cnt_d = expiry_cnt_q + 32'd1;
`ifdef TIMER_CTRL_PERIODIC_EN
    end else if (wr_expcnt_s) begin
      expiry_cnt_d = 32'd0;
`endif
    end else begin
      expiry_cnt_d = expiry_cnt_q;
    end
  end

  // State, configuration and pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prescaler_q  <= 32'd0;
      timer_q      <= 32'd0;
      expired_q    <= 1'b0;
      expiry_cnt_q <= 32'd0;
      core_start_q <= 1'b0;
      core_stop_q  <= 1'b0;
      stop_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescaler_q  <= prescaler_d;
      timer_q      <= timer_d;
      expired_q    <= expired_d;
      expiry_cnt_q <= expiry_cnt_d;
      core_start_q <= core_start_d;
      core_stop_q  <= core_stop_d;
      stop_req_q   <= stop_req_d;
    end
  end

  assign core_prescaler_value = prescaler_q;
  assign core_timer_value     = timer_q;
  assign core_start           = core_start_q;
  assign core_stop            = core_stop_q;

  // Register read mux; unmapped addresses read zero.
  always_comb begin
    read_data = 32'h0000_0000;
    case (address)
      ADDR_CTRL:       read_data = {29'd0, periodic_s, 2'b00};
      ADDR_STATUS:     read_data = {30'd0, expired_q, ~idle_s};
      ADDR_PRESCALER:  read_data = prescaler_q;
      ADDR_TIMER:      read_data = core_curr_timer;
`ifdef TIMER_CTRL_PERIODIC_EN
      ADDR_EXPIRY_CNT: read_data = expiry_cnt_q;
`else
      ADDR_EXPIRY_CNT: read_data = 32'h0000_0000;
`endif
      default:         read_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: self-checking bench for timer_ctrl with a simple counter
// core model. Register reads go through a scoreboard queue.
module tb_timer_ctrl;

  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h09;
  localparam logic [7:0] A_PRESC  = 8'h0a;
  localparam logic [7:0] A_TIMER  = 8'h0b;
  localparam logic [7:0] A_EXPCNT = 8'h0c;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [31:0] core_prescaler_value;
  logic [31:0] core_timer_value;
  logic        core_start;
  logic        core_stop;
  logic [31:0] core_curr_timer;
  logic        core_ready;

  timer_ctrl dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .cs                   (cs),
    .we                   (we),
    .address              (address),
    .write_data           (write_data),
    .read_data            (read_data),
    .ready                (ready),
    .core_prescaler_value (core_prescaler_value),
    .core_timer_value     (core_timer_value),
    .core_start           (core_start),
    .core_stop            (core_stop),
    .core_curr_timer      (core_curr_timer),
    .core_ready           (core_ready)
  );

  always #5 clk = ~clk;

  // Core model: loads the timer on start, counts down, idles on zero or stop.
  logic [31:0] cnt_q;
  always @(posedge clk) begin
    if (!reset_n) begin
      core_ready <= 1'b1;
      cnt_q      <= 32'd0;
    end else if (core_stop) begin
      core_ready <= 1'b1;
    end else if (core_start) begin
      core_ready <= 1'b0;
      cnt_q      <= core_timer_value;
    end else if (!core_ready) begin
      if (cnt_q == 32'd0) core_ready <= 1'b1;
      else                cnt_q <= cnt_q - 32'd1;
    end
  end
  assign core_curr_timer = cnt_q;

  // Pulse monitor.
  int n_start = 0;
  int n_stop  = 0;
  int n_both  = 0;
  always @(negedge clk) begin
    if (core_start) n_start <= n_start + 1;
    if (core_stop)  n_stop  <= n_stop + 1;
    if (core_start && core_stop) n_both <= n_both + 1;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic        start_seen;
  logic        stop_seen;
  int          s0;
  int          p0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives a write for one cycle starting now; samples pulses one cycle later.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    start_seen = core_start;
    stop_seen  = core_stop;
  endtask

  task automatic bus_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] e;
    sb_q.push_back(exp);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    e = sb_q.pop_front();
    chk(tag, read_data, e);
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      cs = 1'b1; we = 1'b0; address = A_STATUS;
      #1;
      if (read_data[0] == 1'b0) done = 1'b1;
      else @(negedge clk);
    end
    cs = 1'b0;
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_ready(input logic lvl);
    for (int i = 0; i < 300; i++) begin
      if (core_ready == lvl) break;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; address = 8'h00; write_data = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_presc", core_prescaler_value, 32'd0);
    chk("rst_timer", core_timer_value, 32'd0);
    chk("rst_start", {31'd0, core_start}, 32'd0);
    chk("rst_stop", {31'd0, core_stop}, 32'd0);
    bus_read("rst_status", A_STATUS, 32'h0);
    bus_read("rst_ctrl", A_CTRL, 32'h0);
    bus_read("rst_expcnt", A_EXPCNT, 32'h0);
    bus_read("unmapped", 8'h3f, 32'h0);

    // One-shot expiry
    bus_write(A_PRESC, 32'd2);
    bus_write(A_TIMER, 32'd3);
    chk("cfg_presc", core_prescaler_value, 32'd2);
    chk("cfg_timer", core_timer_value, 32'd3);
    bus_read("rd_presc", A_PRESC, 32'd2);
    #1 p0 = n_start;
    bus_write(A_CTRL, 32'h1);
    chk("os_start_pulse", {31'd0, start_seen}, 32'd1);
    bus_read("os_running", A_STATUS, 32'h1);
    #1 chk("os_start_width", {31'd0, core_start}, 32'd0);
    chk("ready_eq_cs", {31'd0, ready}, 32'd0);
    bus_read("os_timer_live", A_TIMER, cnt_q);
    wait_idle("os");
    bus_read("os_expired", A_STATUS, 32'h2);
    chk("os_start_cnt", n_start - p0, 32'd1);
`ifdef TIMER_CTRL_PERIODIC_EN
    bus_read("os_expcnt", A_EXPCNT, 32'd1);
`else
    bus_read("os_expcnt", A_EXPCNT, 32'd0);
`endif
    bus_write(A_STATUS, 32'h2);
    bus_read("os_clear", A_STATUS, 32'h0);

    // Busy write protection and start while busy
    #1 p0 = n_start;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TIMER, 32'h55);
    bus_write(A_PRESC, 32'h7);
    bus_write(A_CTRL, 32'h1);
    chk("busy_no_start", {31'd0, start_seen}, 32'd0);
    wait_idle("busy");
    chk("busy_timer", core_timer_value, 32'h3);
    chk("busy_presc", core_prescaler_value, 32'h2);
    chk("busy_start_cnt", n_start - p0, 32'd1);
    bus_write(A_STATUS, 32'h2);

    // Stop during RUN
    bus_write(A_PRESC, 32'd100);
    bus_write(A_TIMER, 32'd100);
    #1 p0 = n_stop;
    bus_write(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    bus_write(A_CTRL, 32'h2);
    chk("stop_pulse", {31'd0, stop_seen}, 32'd1);
    wait_idle("stop");
    chk("stop_cnt", n_stop - p0, 32'd1);
    bus_read("stop_status", A_STATUS, 32'h0);
`ifdef TIMER_CTRL_PERIODIC_EN
    bus_read("stop_expcnt", A_EXPCNT, 32'd2);
`else
    bus_read("stop_expcnt", A_EXPCNT, 32'd0);
`endif

    // Stop while idle: no pulse
    #1 p0 = n_stop;
    bus_write(A_CTRL, 32'h2);
    @(negedge clk);
    #1 chk("idle_stop_cnt", n_stop - p0, 32'd0);

    // Start+stop together, with a STATUS clear landing on the expiry cycle
    bus_write(A_PRESC, 32'd2);
    bus_write(A_TIMER, 32'd3);
    #1 p0 = n_start; s0 = n_stop;
    bus_write(A_CTRL, 32'h3);
    chk("ss_start", {31'd0, start_seen}, 32'd1);
    chk("ss_nostop", {31'd0, stop_seen}, 32'd0);
    wait_ready(1'b0);
    wait_ready(1'b1);
    bus_write(A_STATUS, 32'h2);
    wait_idle("ss");
    bus_read("ss_set_wins", A_STATUS, 32'h2);
    chk("ss_start_cnt", n_start - p0, 32'd1);
    chk("ss_stop_cnt", n_stop - s0, 32'd0);

    // Periodic mode
    bus_write(A_PRESC, 32'd0);
    bus_write(A_TIMER, 32'd1);
`ifdef TIMER_CTRL_PERIODIC_EN
    bus_read("per_expcnt_pre", A_EXPCNT, 32'd3);
    bus_write(A_EXPCNT, 32'hdead_beef);
    bus_read("per_expcnt_clr", A_EXPCNT, 32'd0);
    #1 p0 = n_start; s0 = n_stop;
    bus_write(A_CTRL, 32'h5);
    bus_read("per_ctrl", A_CTRL, 32'h4);
    for (int i = 0; i < 200; i++) begin
      if (n_start - p0 >= 5) break;
      @(negedge clk);
      #1;
    end
    chk("per_starts", n_start - p0, 32'd5);
    bus_read("per_expcnt4", A_EXPCNT, 32'd4);
    bus_write(A_CTRL, 32'h2);
    wait_idle("per");
    chk("per_stop_cnt", n_stop - s0, 32'd1);
    bus_read("per_expcnt_end", A_EXPCNT, 32'd4);
    bus_read("per_status", A_STATUS, 32'h2);
    bus_read("per_ctrl_off", A_CTRL, 32'h0);
`else
    #1 p0 = n_start;
    bus_write(A_CTRL, 32'h5);
    bus_read("per_ctrl_ro", A_CTRL, 32'h0);
    wait_idle("per");
    chk("per_oneshot", n_start - p0, 32'd1);
    bus_read("per_status", A_STATUS, 32'h2);
    bus_read("per_expcnt", A_EXPCNT, 32'h0);
`endif

    // Reset mid-run
    bus_write(A_TIMER, 32'd100);
    bus_write(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mr_presc", core_prescaler_value, 32'd0);
    chk("mr_timer", core_timer_value, 32'd0);
    chk("mr_start", {31'd0, core_start}, 32'd0);
    chk("mr_stop", {31'd0, core_stop}, 32'd0);
    bus_read("mr_status", A_STATUS, 32'h0);
    bus_read("mr_ctrl", A_CTRL, 32'h0);
    bus_read("mr_expcnt", A_EXPCNT, 32'h0);

    chk("no_overlap", n_both, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Bus-facing control stage directly upstream of the timer counter core.
- Holds the prescaler and timer configuration registers and turns CPU register writes into single-cycle start/stop pulses.
- Tracks the core's ready handshake through a small FSM.
- Exposes running and expired status plus the live counter value to the CPU.

Parameters:
ADDR_CTRL, 8'h08, control register word address
ADDR_STATUS, 8'h09, status register word address
ADDR_PRESCALER, 8'h0a, prescaler value register word address
ADDR_TIMER, 8'h0b, timer value register word address (read returns live count)
ADDR_EXPIRY_CNT, 8'h0c, expiry counter word address

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cs  in  1  bus chip select
we  in  1  bus write enable (qualified by cs)
address  in  8  bus word address
write_data  in  32  bus write data
read_data  out  32  bus read data (combinational)
ready  out  1  bus ready, equals cs (zero wait states)
core_prescaler_value  out  32  prescaler_reg to core
core_timer_value  out  32  timer_reg to core
core_start  out  1  registered one-cycle start pulse
core_stop  out  1  registered one-cycle stop pulse
core_curr_timer  in  32  live count from core
core_ready  in  1  core idle flag (1 = idle)

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- Reset values: prescaler_reg=0, timer_reg=0, expired=0, expiry_cnt=0, core_start=0, core_stop=0, periodic=0, FSM=IDLE.
- CTRL write decode: bit0 start, bit1 stop, bit2 periodic (feature only); bits are write-1 actions.
- CTRL read layout: bit2 periodic; bits 1:0 read 0.
- STATUS read layout: bit0 running (FSM != IDLE), bit1 expired (sticky).
- STATUS write: bit1=1 clears expired.
- PRESCALER/TIMER writes are accepted only when FSM==IDLE; they are silently dropped otherwise.
- TIMER read returns core_curr_timer. PRESCALER read returns prescaler_reg.
- Unmapped reads return 32'h0.
- Start write accepted in IDLE at cycle N:
  - core_start=1 in cycle N+1 only.
  - FSM goes to ARM.
- ARM:
  - Waits for core_ready==0, then goes to RUN.
  - A stop write in ARM is latched (stop_req) and forwarded as core_stop once RUN is entered.
- RUN:
  - A stop write sets stop_req and pulses core_stop in the next cycle (one cycle only).
  - When core_ready==1 and stop_req==0: natural expiry. Set expired=1 and increment expiry_cnt (32-bit, wraps 0xffffffff->0).
  - When core_ready==1: if periodic==1 and stop_req==0, pulse core_start and go to ARM; otherwise clear stop_req and go to IDLE.
- Simultaneous events:
  - Start+stop in the same write while IDLE: start honoured, stop ignored.
  - Start while busy: ignored.
  - Stop while IDLE: ignored, no pulse.
  - Expiry and STATUS clear-write in the same cycle: set wins.
- Never assert core_start and core_stop in the same cycle.
- Reset mid-run returns all state to reset values within one clock. The core is reset by the same reset_n.

Optional Feature:
- Macro: TIMER_CTRL_PERIODIC_EN.
- Defined:
  - CTRL bit2 is writable; writes are accepted at any time and take effect at the next expiry.
  - Auto-restart on expiry as described above.
  - ADDR_EXPIRY_CNT reads expiry_cnt; a write of any value clears it to 0.
- Undefined:
  - periodic is tied 0 and CTRL bit2 reads 0.
  - expiry_cnt still counts one-shot expiries.
  - ADDR_EXPIRY_CNT reads 0 and writes are ignored.

Test Plan:
- One-shot expiry: write PRESCALER=2, TIMER=3, then CTRL=1. Required: core_start high exactly one cycle after the write; STATUS=0x1 while running; STATUS=0x2 after core_ready returns 1; expiry_cnt=1.
- Stop: start with PRESCALER=100, TIMER=100, then write CTRL=2 during RUN. Required: a single core_stop pulse; STATUS=0x0 after core_ready=1; expired=0; expiry_cnt unchanged.
- Busy write protection: write TIMER=0x55 while running. Required: TIMER register still 0x3 after return to IDLE; a start while running produces no core_start.
- Simultaneous start+stop: write CTRL=3 in IDLE. Required: one core_start, no core_stop, normal expiry.
- Periodic (macro defined): write PRESCALER=0, TIMER=1, CTRL=5. Required: core_start re-pulses after each expiry; expiry_cnt=4 after four periods; CTRL=2 ends the run with the FSM in IDLE.
- Reset mid-run: assert reset_n=0 for one cycle during RUN. Required: all outputs and registers return to reset values; STATUS=0x0.
